bus_interface_unit: RTL and testbench



---
 rtl/biu_pkg.sv | 26 ++
 rtl/biu_if.sv | 46 ++++
 rtl/bus_interface_unit.sv | 141 ++++++++++++++
 tb/tb_bus_interface_unit.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/biu_pkg.sv
// Shared types and constants for the 8085-style bus interface unit.
package biu_pkg;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;

   // Machine-cycle states; HOLD is only reachable when BIU_HOLD_EN is defined.
   typedef enum logic [2:0] {
      IDLE,
      T1,
      T2,
      TW,
      T3,
      HOLD
   } biu_state_t;

   // Status pin encodings {s1, s0}.
   localparam logic [1:0] S_READ  = 2'b10;
   localparam logic [1:0] S_WRITE = 2'b01;

   // Status encoding for a latched cycle direction.
   function automatic logic [1:0] status_bits(input logic we);
      return we ? S_WRITE : S_READ;
   endfunction

endpackage

// File: rtl/biu_if.sv
// Bus interface unit signal bundle: the control-unit request side plus the
// external multiplexed address/data bus. The master modport is the
// environment (control unit and external bus); the slave modport is the BIU.
interface biu_if;
   import biu_pkg::*;

   // Control-unit side
   logic                     req;
   logic                     we;
   logic                     io_m;
   logic [ADDR_W-1:0]        addr;
   logic [DATA_W-1:0]        wdata;
   logic                     busy;
   logic                     done;
   logic                     err;
   logic [DATA_W-1:0]        rdata;

   // External bus side
   logic                     ready;
   logic [ADDR_W-DATA_W-1:0] a_hi;
   logic [DATA_W-1:0]        ad_out;
   logic [DATA_W-1:0]        ad_in;
   logic                     ad_oe;
   logic                     a_oe;
   logic                     ale;
   logic                     rd_n;
   logic                     wr_n;
   logic                     io_m_out;
   logic                     s1;
   logic                     s0;
   logic                     hold;
   logic                     hlda;

   modport master (
      output req, we, io_m, addr, wdata, ready, ad_in, hold,
      input  busy, done, err, rdata, a_hi, ad_out, ad_oe, a_oe, ale,
             rd_n, wr_n, io_m_out, s1, s0, hlda
   );

   modport slave (
      input  req, we, io_m, addr, wdata, ready, ad_in, hold,
      output busy, done, err, rdata, a_hi, ad_out, ad_oe, a_oe, ale,
             rd_n, wr_n, io_m_out, s1, s0, hlda
   );

endinterface

// File: rtl/bus_interface_unit.sv
// 8085-style bus interface unit: runs one T1/T2/[TW...]/T3 machine cycle per
// accepted request and reports completion with a one-cycle done pulse.
// WAIT_LIMIT bounds consecutive wait states (0 = unlimited).
// Optional bus hold/acknowledge support is compiled in by BIU_HOLD_EN.
module bus_interface_unit
   import biu_pkg::*;
#(
   parameter int WAIT_LIMIT = 0
) (
   input logic  clk,
   input logic  reset,
   biu_if.slave bus
);

   localparam int CNT_W = 16;

   biu_state_t        state;
   biu_state_t        state_nxt;
   logic [ADDR_W-1:0] lat_addr;
   logic              lat_we;
   logic              lat_io;
   logic [DATA_W-1:0] lat_wdata;
   logic [CNT_W-1:0]  wait_cnt;
   logic              err_flag;
   logic              done_q;
   logic              err_q;
   logic [DATA_W-1:0] rdata_q;
   logic              limit_hit;
   logic              hold_req;

`ifdef BIU_HOLD_EN
   assign hold_req = bus.hold;
`else
   logic unused_hold;
   assign unused_hold = bus.hold;
   assign hold_req    = 1'b0;
`endif

   assign limit_hit = (WAIT_LIMIT != 0) && (wait_cnt == CNT_W'(WAIT_LIMIT));

   // State register
   always_ff @(posedge clk) begin
      // NOTE: every flop uses non-blocking (<=) so all registers see pre-edge values.
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state decode
   always_comb begin
      // NOTE: default assigned first so no path leaves it unassigned (no latch).
      state_nxt = state;
      unique case (state)
         IDLE:    if (hold_req)     state_nxt = HOLD;
                  else if (bus.req) state_nxt = T1;
         T1:      state_nxt = T2;
         T2:      state_nxt = bus.ready ? T3 : TW;
         TW:      state_nxt = (bus.ready || limit_hit) ? T3 : TW;
         T3:      state_nxt = hold_req ? HOLD : IDLE;
         HOLD:    if (!hold_req)    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latches, wait counter, completion pulses and read data capture
   always_ff @(posedge clk) begin
      if (reset) begin
         lat_addr  <= '0;
         lat_we    <= 1'b0;
         lat_io    <= 1'b0;
         lat_wdata <= '0;
         wait_cnt  <= '0;
         err_flag  <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         if (state == IDLE && state_nxt == T1) begin
            lat_addr  <= bus.addr;
            lat_we    <= bus.we;
            lat_io    <= bus.io_m;
            lat_wdata <= bus.wdata;
         end
         if (state_nxt == T1) begin
            wait_cnt <= '0;
            err_flag <= 1'b0;
         end else if (state_nxt == TW && wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
         end
         if (state == TW && limit_hit) err_flag <= 1'b1;
         done_q <= (state == T3);
         err_q  <= (state == T3) && err_flag;
         if (state == T3 && !lat_we) rdata_q <= bus.ad_in;
      end
   end

   // Moore bus-pin decode from state and latched request
   always_comb begin
      bus.ale      = 1'b0;
      bus.rd_n     = 1'b1;
      bus.wr_n     = 1'b1;
      bus.ad_oe    = 1'b0;
      bus.ad_out   = '0;
      bus.a_oe     = 1'b1;
      bus.hlda     = 1'b0;
      bus.s1       = 1'b0;
      bus.s0       = 1'b0;
      bus.io_m_out = 1'b0;
      unique case (state)
         T1: begin
            bus.ale            = 1'b1;
            bus.ad_out         = lat_addr[DATA_W-1:0];
            bus.ad_oe          = 1'b1;
            {bus.s1, bus.s0}   = status_bits(lat_we);
            bus.io_m_out       = lat_io;
         end
         T2, TW, T3: begin
            {bus.s1, bus.s0}   = status_bits(lat_we);
            bus.io_m_out       = lat_io;
            if (lat_we) begin
               bus.wr_n   = 1'b0;
               bus.ad_out = lat_wdata;
               bus.ad_oe  = 1'b1;
            end else begin
               bus.rd_n   = 1'b0;
            end
         end
         HOLD: begin
            bus.a_oe = 1'b0;
            bus.hlda = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.busy  = (state != IDLE);
   assign bus.done  = done_q;
   assign bus.err   = err_q;
   assign bus.rdata = rdata_q;
   assign bus.a_hi  = lat_addr[ADDR_W-1:DATA_W];

endmodule

// File: tb/tb_bus_interface_unit.sv
// Self-checking bench for bus_interface_unit: a per-cycle vector table on a
// WAIT_LIMIT=0 instance, plus hand sequences for the wait limit (second
// instance, WAIT_LIMIT=2) and the optional hold feature.
module tb_bus_interface_unit;

   logic clk = 1'b0;
   logic reset;
   int   pass_cnt = 0;
   int   total_cnt = 0;

   always #5 clk = ~clk;

   biu_if bus0 ();
   biu_if bus2 ();

   bus_interface_unit #(.WAIT_LIMIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
   bus_interface_unit #(.WAIT_LIMIT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

   // One cycle: inputs present during the cycle, outputs observed during it.
   typedef struct {
      logic        rst, req, we, io_m;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic        ready;
      logic [7:0]  ad_in;
      logic        busy, done, err, ale, rd_n, wr_n, ad_oe;
      logic [7:0]  ad_out, a_hi;
      logic [1:0]  st;
      logic        io_o;
      logic [7:0]  rdata;
   } vec_t;

   vec_t vecs[41];

   function automatic vec_t row(
      input logic rst, req, we, io_m, input logic [15:0] addr, input logic [7:0] wdata,
      input logic ready, input logic [7:0] ad_in,
      input logic busy, done, err, ale, rd_n, wr_n, ad_oe,
      input logic [7:0] ad_out, a_hi, input logic [1:0] st, input logic io_o,
      input logic [7:0] rdata);
      vec_t v;
      v.rst = rst; v.req = req; v.we = we; v.io_m = io_m; v.addr = addr;
      v.wdata = wdata; v.ready = ready; v.ad_in = ad_in;
      v.busy = busy; v.done = done; v.err = err; v.ale = ale; v.rd_n = rd_n;
      v.wr_n = wr_n; v.ad_oe = ad_oe; v.ad_out = ad_out; v.a_hi = a_hi;
      v.st = st; v.io_o = io_o; v.rdata = rdata;
      return v;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic drive0(input logic req, we, io_m, input logic [15:0] addr,
                         input logic [7:0] wdata, input logic ready, input logic [7:0] ad_in,
                         input logic hold);
      bus0.req = req; bus0.we = we; bus0.io_m = io_m; bus0.addr = addr;
      bus0.wdata = wdata; bus0.ready = ready; bus0.ad_in = ad_in; bus0.hold = hold;
   endtask

   initial begin
      // Columns: rst req we io addr wdata ready ad_in | busy done err ale rd_n wr_n ad_oe ad_out a_hi {s1,s0} io_m_out rdata
      // Memory read 2050, ready=1
      vecs[0]  = row(0,1,0,0,16'h2050,8'h00,1,8'h00, 0,0,0,0,1,1,0,8'h00,8'h00,2'b00,0,8'h00);
      vecs[1]  = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 1,0,0,1,1,1,1,8'h50,8'h20,2'b10,0,8'h00);
      vecs[2]  = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 1,0,0,0,0,1,0,8'h00,8'h20,2'b10,0,8'h00);
      vecs[3]  = row(0,0,0,0,16'h0000,8'h00,1,8'hA5, 1,0,0,0,0,1,0,8'h00,8'h20,2'b10,0,8'h00);
      // Done cycle; new I/O write request accepted here
      vecs[4]  = row(0,1,1,1,16'h00F1,8'h3C,1,8'h00, 0,1,0,0,1,1,0,8'h00,8'h20,2'b00,0,8'hA5);
      vecs[5]  = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 1,0,0,1,1,1,1,8'hF1,8'h00,2'b01,1,8'hA5);
      vecs[6]  = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 1,0,0,0,1,0,1,8'h3C,8'h00,2'b01,1,8'hA5);
      vecs[7]  = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 1,0,0,0,1,0,1,8'h3C,8'h00,2'b01,1,8'hA5);
      vecs[8]  = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 0,1,0,0,1,1,0,8'h00,8'h00,2'b00,0,8'hA5);
      // Read 1234 with three wait states
      vecs[9]  = row(0,1,0,0,16'h1234,8'h00,1,8'h00, 0,0,0,0,1,1,0,8'h00,8'h00,2'b00,0,8'hA5);
      vecs[10] = row(0,0,0,0,16'h0000,8'h00,0,8'h00, 1,0,0,1,1,1,1,8'h34,8'h12,2'b10,0,8'hA5);
      vecs[11] = row(0,0,0,0,16'h0000,8'h00,0,8'h00, 1,0,0,0,0,1,0,8'h00,8'h12,2'b10,0,8'hA5);
      vecs[12] = row(0,0,0,0,16'h0000,8'h00,0,8'h00, 1,0,0,0,0,1,0,8'h00,8'h12,2'b10,0,8'hA5);
      vecs[13] = row(0,0,0,0,16'h0000,8'h00,0,8'h00, 1,0,0,0,0,1,0,8'h00,8'h12,2'b10,0,8'hA5);
      vecs[14] = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 1,0,0,0,0,1,0,8'h00,8'h12,2'b10,0,8'hA5);
      vecs[15] = row(0,0,0,0,16'h0000,8'h00,1,8'h5A, 1,0,0,0,0,1,0,8'h00,8'h12,2'b10,0,8'hA5);
      vecs[16] = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 0,1,0,0,1,1,0,8'h00,8'h12,2'b00,0,8'h5A);
      // Memory write 4000 with a stray req during T2
      vecs[17] = row(0,1,1,0,16'h4000,8'h77,1,8'h00, 0,0,0,0,1,1,0,8'h00,8'h12,2'b00,0,8'h5A);
      vecs[18] = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 1,0,0,1,1,1,1,8'h00,8'h40,2'b01,0,8'h5A);
      vecs[19] = row(0,1,0,0,16'hFFFF,8'h00,1,8'h00, 1,0,0,0,1,0,1,8'h77,8'h40,2'b01,0,8'h5A);
      vecs[20] = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 1,0,0,0,1,0,1,8'h77,8'h40,2'b01,0,8'h5A);
      vecs[21] = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 0,1,0,0,1,1,0,8'h00,8'h40,2'b00,0,8'h5A);
      vecs[22] = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 0,0,0,0,1,1,0,8'h00,8'h40,2'b00,0,8'h5A);
      // req held high: accepted in IDLE and again in the done cycle
      vecs[23] = row(0,1,0,0,16'h0102,8'h00,1,8'h00, 0,0,0,0,1,1,0,8'h00,8'h40,2'b00,0,8'h5A);
      vecs[24] = row(0,1,0,0,16'h0102,8'h00,1,8'h00, 1,0,0,1,1,1,1,8'h02,8'h01,2'b10,0,8'h5A);
      vecs[25] = row(0,1,0,0,16'h0102,8'h00,1,8'h00, 1,0,0,0,0,1,0,8'h00,8'h01,2'b10,0,8'h5A);
      vecs[26] = row(0,1,0,0,16'h0102,8'h00,1,8'h11, 1,0,0,0,0,1,0,8'h00,8'h01,2'b10,0,8'h5A);
      vecs[27] = row(0,1,0,0,16'h0102,8'h00,1,8'h00, 0,1,0,0,1,1,0,8'h00,8'h01,2'b00,0,8'h11);
      vecs[28] = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 1,0,0,1,1,1,1,8'h02,8'h01,2'b10,0,8'h11);
      vecs[29] = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 1,0,0,0,0,1,0,8'h00,8'h01,2'b10,0,8'h11);
      vecs[30] = row(0,0,0,0,16'h0000,8'h00,1,8'h22, 1,0,0,0,0,1,0,8'h00,8'h01,2'b10,0,8'h11);
      vecs[31] = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 0,1,0,0,1,1,0,8'h00,8'h01,2'b00,0,8'h22);
      // Reset asserted during TW, then a normal read
      vecs[32] = row(0,1,0,0,16'h3344,8'h00,0,8'h00, 0,0,0,0,1,1,0,8'h00,8'h01,2'b00,0,8'h22);
      vecs[33] = row(0,0,0,0,16'h0000,8'h00,0,8'h00, 1,0,0,1,1,1,1,8'h44,8'h33,2'b10,0,8'h22);
      vecs[34] = row(0,0,0,0,16'h0000,8'h00,0,8'h00, 1,0,0,0,0,1,0,8'h00,8'h33,2'b10,0,8'h22);
      vecs[35] = row(1,0,0,0,16'h0000,8'h00,0,8'h00, 1,0,0,0,0,1,0,8'h00,8'h33,2'b10,0,8'h22);
      vecs[36] = row(0,1,0,0,16'h5566,8'h00,1,8'h00, 0,0,0,0,1,1,0,8'h00,8'h00,2'b00,0,8'h00);
      vecs[37] = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 1,0,0,1,1,1,1,8'h66,8'h55,2'b10,0,8'h00);
      vecs[38] = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 1,0,0,0,0,1,0,8'h00,8'h55,2'b10,0,8'h00);
      vecs[39] = row(0,0,0,0,16'h0000,8'h00,1,8'h9C, 1,0,0,0,0,1,0,8'h00,8'h55,2'b10,0,8'h00);
      vecs[40] = row(0,0,0,0,16'h0000,8'h00,1,8'h00, 0,1,0,0,1,1,0,8'h00,8'h55,2'b00,0,8'h9C);

      reset = 1'b1;
      drive0(0, 0, 0, 16'h0000, 8'h00, 1, 8'h00, 0);
      bus2.req = 0; bus2.we = 0; bus2.io_m = 0; bus2.addr = 16'h0000;
      bus2.wdata = 8'h00; bus2.ready = 0; bus2.ad_in = 8'h00; bus2.hold = 0;
      repeat (2) @(posedge clk);

      // Table-driven per-cycle checks on the WAIT_LIMIT=0 instance
      for (int i = 0; i < 41; i++) begin
         @(posedge clk); #1;
         reset = vecs[i].rst;
         drive0(vecs[i].req, vecs[i].we, vecs[i].io_m, vecs[i].addr, vecs[i].wdata,
                vecs[i].ready, vecs[i].ad_in, 0);
         @(negedge clk);
         check($sformatf("row%0d.busy", i),  16'(bus0.busy),  16'(vecs[i].busy));
         check($sformatf("row%0d.done", i),  16'(bus0.done),  16'(vecs[i].done));
         check($sformatf("row%0d.err", i),   16'(bus0.err),   16'(vecs[i].err));
         check($sformatf("row%0d.ale", i),   16'(bus0.ale),   16'(vecs[i].ale));
         check($sformatf("row%0d.rd_n", i),  16'(bus0.rd_n),  16'(vecs[i].rd_n));
         check($sformatf("row%0d.wr_n", i),  16'(bus0.wr_n),  16'(vecs[i].wr_n));
         check($sformatf("row%0d.ad_oe", i), 16'(bus0.ad_oe), 16'(vecs[i].ad_oe));
         if (vecs[i].ad_oe)
            check($sformatf("row%0d.ad_out", i), 16'(bus0.ad_out), 16'(vecs[i].ad_out));
         check($sformatf("row%0d.a_hi", i),  16'(bus0.a_hi),  16'(vecs[i].a_hi));
         check($sformatf("row%0d.status", i), 16'({bus0.s1, bus0.s0}), 16'(vecs[i].st));
         check($sformatf("row%0d.io_m_out", i), 16'(bus0.io_m_out), 16'(vecs[i].io_o));
         check($sformatf("row%0d.rdata", i), 16'(bus0.rdata), 16'(vecs[i].rdata));
         check($sformatf("row%0d.a_oe", i),  16'(bus0.a_oe),  16'h0001);
         check($sformatf("row%0d.hlda", i),  16'(bus0.hlda),  16'h0000);
      end

      // WAIT_LIMIT=2 with ready stuck low: T1,T2,TW,TW,T3 then done+err
      for (int c = 0; c <= 7; c++) begin
         @(posedge clk); #1;
         bus2.req  = (c == 0);
         bus2.addr = (c == 0) ? 16'hABCD : 16'h0000;
         bus2.ready = 1'b0;
         bus2.ad_in = (c == 5) ? 8'hE7 : 8'h00;
         @(negedge clk);
         check($sformatf("wl%0d.busy", c), 16'(bus2.busy), 16'((c >= 1) && (c <= 5)));
         check($sformatf("wl%0d.rd_n", c), 16'(bus2.rd_n), 16'(!((c >= 2) && (c <= 5))));
         check($sformatf("wl%0d.done", c), 16'(bus2.done), 16'(c == 6));
         check($sformatf("wl%0d.err", c),  16'(bus2.err),  16'(c == 6));
      end
      check("wl.rdata", 16'(bus2.rdata), 16'h00E7);

`ifdef BIU_HOLD_EN
      // hold raised during T2: cycle completes, then HOLD until hold drops
      for (int c = 0; c <= 7; c++) begin
         @(posedge clk); #1;
         drive0((c == 0) || (c == 4), 0, 0, (c == 0) ? 16'h7788 : 16'h0000, 8'h00, 1,
                (c == 3) ? 8'h66 : 8'h00, (c >= 2) && (c <= 4));
         @(negedge clk);
         check($sformatf("hold%0d.busy", c), 16'(bus0.busy), 16'((c >= 1) && (c <= 5)));
         check($sformatf("hold%0d.hlda", c), 16'(bus0.hlda), 16'((c == 4) || (c == 5)));
         check($sformatf("hold%0d.a_oe", c), 16'(bus0.a_oe), 16'(!((c == 4) || (c == 5))));
         check($sformatf("hold%0d.done", c), 16'(bus0.done), 16'(c == 4));
         check($sformatf("hold%0d.rd_n", c), 16'(bus0.rd_n), 16'(!((c == 2) || (c == 3))));
         check($sformatf("hold%0d.ad_oe", c), 16'(bus0.ad_oe), 16'(c == 1));
      end
      check("hold.rdata", 16'(bus0.rdata), 16'h0066);
`else
      // hold is ignored: request with hold=1 runs a normal cycle, hlda stays 0
      for (int c = 0; c <= 5; c++) begin
         @(posedge clk); #1;
         drive0(c == 0, 0, 0, (c == 0) ? 16'h7788 : 16'h0000, 8'h00, 1,
                (c == 3) ? 8'h66 : 8'h00, 1'b1);
         @(negedge clk);
         check($sformatf("nohold%0d.busy", c), 16'(bus0.busy), 16'((c >= 1) && (c <= 3)));
         check($sformatf("nohold%0d.ale", c),  16'(bus0.ale),  16'(c == 1));
         check($sformatf("nohold%0d.hlda", c), 16'(bus0.hlda), 16'h0000);
         check($sformatf("nohold%0d.a_oe", c), 16'(bus0.a_oe), 16'h0001);
         check($sformatf("nohold%0d.done", c), 16'(bus0.done), 16'(c == 4));
      end
      check("nohold.rdata", 16'(bus0.rdata), 16'h0066);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
